// File: rtl/ps2_kbd_serializer.sv
// Device-side PS/2 keyboard transmitter: scan-code FIFO feeding an 11-bit frame
// serialiser that drives registered ps2_clk/ps2_dat lines (transmit only).
module ps2_kbd_serializer #(
    parameter int CLK_DIV    = 2000,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_HALVES = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       full,
    output logic       overflow,
    output logic       busy,
    output logic       ps2_clk,
    output logic       ps2_dat
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(GAP_HALVES * CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_HALVES * CLK_DIV - 1);
    localparam logic [PW-1:0]    DEPTH_V  = PW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Frame bit i is transmitted i-th: start, data LSB first, parity, stop.
    function automatic logic [10:0] make_frame(input logic [7:0] d);
        return {1'b1, odd_parity(d), d, 1'b0};
    endfunction

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    count;
    logic             empty;

    state_t           state_r, state_next;
    logic [DIV_W-1:0] div_r, div_next;
    logic [GAP_W-1:0] gap_r, gap_next;
    logic [3:0]       idx_r, idx_next;
    logic [10:0]      frame_r, frame_next;
    logic             pop;
    logic             clk_next;
    logic             dat_next;

    assign count = wr_ptr - rd_ptr;
    assign empty = (count == {PW{1'b0}});
    assign full  = (count == DEPTH_V);
    assign busy  = (state_r != IDLE) || !empty;

    // FIFO storage; no reset needed, visibility is governed by the pointers.
    always_ff @(posedge clk_sys) begin
        if (wr_en && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Write pointer and overflow pulse; full is judged before any same-cycle pop.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr   <= {PW{1'b0}};
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;
            if (wr_en && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Next-state, counter reloads and next line levels.
    always_comb begin
        state_next = state_r;
        div_next   = div_r;
        gap_next   = gap_r;
        idx_next   = idx_r;
        frame_next = frame_r;
        pop        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    frame_next = make_frame(mem[rd_ptr[AW-1:0]]);
                    idx_next   = 4'd0;
                    div_next   = DIV_LOAD;
                    state_next = HIGH;
                end else begin
                    div_next = {DIV_W{1'b0}};
                end
            end
            HIGH: begin
                if (div_r == {DIV_W{1'b0}}) begin
                    div_next   = DIV_LOAD;
                    state_next = LOW;
                end else begin
                    div_next = div_r - 1'b1;
                end
            end
            LOW: begin
                if (div_r == {DIV_W{1'b0}}) begin
                    div_next = DIV_LOAD;
                    if (idx_r == 4'd10) begin
                        gap_next   = GAP_LOAD;
                        state_next = GAP;
                    end else begin
                        idx_next   = idx_r + 4'd1;
                        state_next = HIGH;
                    end
                end else begin
                    div_next = div_r - 1'b1;
                end
            end
            GAP: begin
                if (gap_r == {GAP_W{1'b0}}) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_r - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Data only moves on the edge entering HIGH, so it is stable across each fall.
        clk_next = (state_next != LOW);
        if ((state_next == HIGH) || (state_next == LOW)) begin
            dat_next = frame_next[idx_next];
        end else begin
            dat_next = 1'b1;
        end
    end

    // FSM state, counters, read pointer and registered PS/2 lines.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            div_r   <= {DIV_W{1'b0}};
            gap_r   <= {GAP_W{1'b0}};
            idx_r   <= 4'd0;
            frame_r <= 11'h7FF;
            rd_ptr  <= {PW{1'b0}};
            ps2_clk <= 1'b1;
            ps2_dat <= 1'b1;
        end else begin
            state_r <= state_next;
            div_r   <= div_next;
            gap_r   <= gap_next;
            idx_r   <= idx_next;
            frame_r <= frame_next;
            ps2_clk <= clk_next;
            ps2_dat <= dat_next;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_serializer.sv
// Bench for ps2_kbd_serializer: directed and random scan codes checked by a
// behavioural PS/2 receiver that decodes frames on falling ps2_clk.
module tb_ps2_kbd_serializer;

    localparam int DIV = 4;

    logic       clk_sys = 1'b0;
    logic       rst     = 1'b1;
    logic [7:0] wr_data, wr_data2;
    logic       wr_en, wr_en2;
    logic       full, overflow, busy, ps2_clk, ps2_dat;
    logic       full2, overflow2, busy2, ps2_clk2, ps2_dat2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    ps2_kbd_serializer #(.CLK_DIV(DIV), .FIFO_DEPTH(4), .GAP_HALVES(2)) u_dut (
        .clk_sys(clk_sys), .reset(rst), .wr_data(wr_data), .wr_en(wr_en),
        .full(full), .overflow(overflow), .busy(busy),
        .ps2_clk(ps2_clk), .ps2_dat(ps2_dat)
    );

    ps2_kbd_serializer #(.CLK_DIV(2000), .FIFO_DEPTH(8), .GAP_HALVES(4)) u_big (
        .clk_sys(clk_sys), .reset(rst), .wr_data(wr_data2), .wr_en(wr_en2),
        .full(full2), .overflow(overflow2), .busy(busy2),
        .ps2_clk(ps2_clk2), .ps2_dat(ps2_dat2)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk_sys);
        #1;
    endtask

    // Reference receiver: samples data on each ps2_clk fall, times half-periods.
    logic        prev_clk = 1'b1, prev_dat = 1'b1, in_low = 1'b0, had_frame = 1'b0;
    int          nbits = 0, nfalls = 0, t_fall = 0, t_rise = 0, t_datf = 0, last_gap = 0;
    logic [9:0]  bits = '0;
    logic [10:0] last_frame = '0;
    logic [7:0]  rxq[$];
    logic        parq[$];

    always @(negedge clk_sys) begin
        prev_clk <= ps2_clk;
        prev_dat <= ps2_dat;
        if (rst) begin
            nbits     <= 0;
            in_low    <= 1'b0;
            had_frame <= 1'b0;
        end else begin
            if (ps2_dat != prev_dat) chk("dat_moves_while_clk_high", ps2_clk, 1);
            if (prev_dat && !ps2_dat && ps2_clk && nbits == 0) begin
                t_datf <= cyc;
                if (had_frame) last_gap <= cyc - t_rise;
            end
            if (prev_clk && !ps2_clk) begin
                nfalls <= nfalls + 1;
                t_fall <= cyc;
                in_low <= 1'b1;
                if (nbits == 0) chk("high_start_len", cyc - t_datf, DIV);
                else            chk("high_len", cyc - t_rise, DIV);
                if (nbits < 10) begin
                    bits[nbits] <= ps2_dat;
                    nbits       <= nbits + 1;
                end else begin
                    chk("start_bit", bits[0], 0);
                    chk("odd_parity", ^bits[9:1], 1);
                    chk("stop_bit", ps2_dat, 1);
                    last_frame <= {ps2_dat, bits};
                    rxq.push_back(bits[8:1]);
                    parq.push_back(bits[9]);
                    nbits     <= 0;
                    had_frame <= 1'b1;
                end
            end
            if (!prev_clk && ps2_clk) begin
                t_rise <= cyc;
                in_low <= 1'b0;
                if (in_low) chk("low_len", cyc - t_fall, DIV);
            end
        end
    end

    task automatic send(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        logic [7:0]  t3 [5];
        logic [7:0]  expq[$];
        logic [7:0]  d;
        logic [10:0] rx6;
        int          t0, f0;

        wr_en = 1'b0; wr_data = 8'h00; wr_en2 = 1'b0; wr_data2 = 8'h00;
        rst = 1'b1;
        repeat (3) step();
        chk("rst_ps2_clk", ps2_clk, 1);
        chk("rst_ps2_dat", ps2_dat, 1);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_big_lines", {ps2_clk2, ps2_dat2, full2, overflow2, busy2}, 5'b11000);
        rst = 1'b0;
        step();

        // 1: single byte 0x1C
        send(8'h1C);
        chk("t1_dat_before_pop", ps2_dat, 1);
        step();
        chk("t1_dat_falls_2_cycles", ps2_dat, 0);
        for (int n = 0; n < 400 && rxq.size() < 1; n++) step();
        chk("t1_rx_count", rxq.size(), 1);
        chk("t1_rx_byte", rxq[0], 8'h1C);
        chk("t1_frame_bits", last_frame, 11'h438);
        for (int n = 0; n < 40 && busy; n++) step();
        chk("t1_busy_low", busy, 0);
        chk("t1_busy_after_rise", cyc - t_rise, 8);

        // 2: back-to-back 0xF0, 0x1C
        rxq.delete(); parq.delete();
        wr_en = 1'b1; wr_data = 8'hF0; step();
        wr_data = 8'h1C; step();
        wr_en = 1'b0;
        for (int n = 0; n < 600 && rxq.size() < 2; n++) step();
        chk("t2_rx_count", rxq.size(), 2);
        chk("t2_byte0", rxq[0], 8'hF0);
        chk("t2_byte1", rxq[1], 8'h1C);
        chk("t2_parity0", parq[0], 1);
        chk("t2_parity1", parq[1], 0);
        chk("t2_inter_frame_gap", last_gap, 9);
        for (int n = 0; n < 40 && busy; n++) step();
        chk("t2_idle", busy, 0);

        // 3: fill FIFO then overflow
        rxq.delete();
        t3[0] = 8'h16; t3[1] = 8'h1E; t3[2] = 8'h26; t3[3] = 8'h25; t3[4] = 8'h2E;
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = t3[i];
            step();
        end
        chk("t3_full", full, 1);
        chk("t3_no_overflow_yet", overflow, 0);
        wr_data = 8'h36;
        step();
        wr_en = 1'b0;
        chk("t3_overflow_pulse", overflow, 1);
        step();
        chk("t3_overflow_one_cycle", overflow, 0);
        for (int n = 0; n < 800 && (rxq.size() < 5 || busy); n++) step();
        chk("t3_rx_count", rxq.size(), 5);
        for (int i = 0; i < 5; i++) chk("t3_rx_byte", rxq[i], t3[i]);

        // 4: reset mid-frame
        rxq.delete();
        send(8'hFF);
        for (int n = 0; n < 200 && nbits < 3; n++) step();
        chk("t4_third_fall", nbits, 3);
        rst = 1'b1;
        #1;
        chk("t4_clk_high", ps2_clk, 1);
        chk("t4_dat_high", ps2_dat, 1);
        chk("t4_busy_low", busy, 0);
        step(); step();
        rst = 1'b0;
        f0 = nfalls;
        repeat (100) step();
        chk("t4_no_edges", nfalls, f0);
        chk("t4_no_bytes", rxq.size(), 0);
        chk("t4_still_idle", {busy, ps2_clk, ps2_dat}, 3'b011);

        // 5: random scan codes with random write gaps
        rxq.delete();
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 120)) step();
            for (int n = 0; n < 1000 && full; n++) step();
            d = 8'($urandom);
            send(d);
            expq.push_back(d);
        end
        for (int n = 0; n < 30000 && rxq.size() < expq.size(); n++) step();
        chk("t5_rx_count", rxq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) chk("t5_rx_byte", rxq[i], expq[i]);

        // 6: full-size divider
        d = 8'h5A;
        wr_en2 = 1'b1; wr_data2 = d; step(); wr_en2 = 1'b0;
        for (int n = 0; n < 10 && ps2_dat2; n++) step();
        chk("t6_dat_fall", ps2_dat2, 0);
        t0 = cyc;
        for (int n = 0; n < 3000 && ps2_clk2; n++) step();
        chk("t6_first_fall_delay", cyc - t0, 2000);
        rx6 = '0;
        for (int k = 0; k < 11; k++) begin
            if (k > 0) begin
                for (int n = 0; n < 3000 && !ps2_clk2; n++) step();
                for (int n = 0; n < 3000 && ps2_clk2; n++) step();
            end
            rx6[k] = ps2_dat2;
        end
        for (int n = 0; n < 3000 && !ps2_clk2; n++) step();
        chk("t6_frame_len", cyc - t0, 44000);
        chk("t6_frame_bits", rx6, {1'b1, ~^d, d, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
